// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADC window integrator.
package adc_pkg;

  localparam int DW       = 13;
  localparam int LENW     = 8;
  // Smallest accumulator that holds len full-scale (DW+1)-bit terms without wrap.
  localparam int SUMW_MIN = DW + 1 + LENW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ACC   = 2'd2
  } win_state_e;

endpackage

// File: rtl/window_ctrl.sv
// Window sequencer: trigger acceptance, delay/length down-counting, busy and
// trig_miss generation, and the acc_clr/acc_en/done strobes for the datapath.
module window_ctrl import adc_pkg::*; #(
  parameter int LENW = adc_pkg::LENW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trig,
  input  logic [LENW-1:0] delay,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            trig_miss,
  output logic            acc_clr,
  output logic            acc_en,
  output logic            done
);

  win_state_e      state_q, state_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [LENW-1:0] len_q, len_d;
  logic            zero_pend_q, zero_pend_d;
  logic            miss_seen_q, miss_seen_d;
  logic            trig_miss_q, trig_miss_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    zero_pend_d = 1'b0;
    miss_seen_d = trig && (state_q != IDLE);
    trig_miss_d = miss_seen_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    done        = zero_pend_q;

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          acc_clr = 1'b1;
          len_d   = len;
          if (delay != '0) begin
            state_d = DELAY;
            cnt_d   = delay;
          end else if (len != '0) begin
            state_d = ACC;
            cnt_d   = len;
          end else begin
            // Empty window: result next cycle without ever leaving IDLE, so busy stays low.
            zero_pend_d = 1'b1;
          end
        end
      end
      DELAY: begin
        if (cnt_q == LENW'(1)) begin
          state_d = ACC;
          cnt_d   = len_q;
        end else begin
          cnt_d = cnt_q - LENW'(1);
        end
      end
      ACC: begin
        // One extra cycle at cnt=0 lets the last sample land before the result is registered.
        if (cnt_q != '0) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q - LENW'(1);
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      zero_pend_q <= 1'b0;
      miss_seen_q <= 1'b0;
      trig_miss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      zero_pend_q <= zero_pend_d;
      miss_seen_q <= miss_seen_d;
      trig_miss_q <= trig_miss_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign trig_miss = trig_miss_q;

endmodule

// File: rtl/adc_window_integrator.sv
// Triggered, delayed window sum of signed ADC samples with a registered result strobe.
// Optional build macro ADC_BASELINE_SUB_EN subtracts the sample seen at the trigger edge.
module adc_window_integrator #(
  parameter int DW   = adc_pkg::DW,
  parameter int LENW = adc_pkg::LENW,
  parameter int SUMW = adc_pkg::SUMW_MIN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [DW-1:0]   din,
  input  logic                   trig,
  input  logic        [LENW-1:0] delay,
  input  logic        [LENW-1:0] len,
  output logic                   busy,
  output logic signed [SUMW-1:0] sum_out,
  output logic                   sum_valid,
  output logic                   trig_miss
);

  logic acc_clr, acc_en, done;

  window_ctrl #(.LENW(LENW)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .delay     (delay),
    .len       (len),
    .busy      (busy),
    .trig_miss (trig_miss),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .done      (done)
  );

  logic signed [SUMW-1:0] term;
  logic signed [SUMW-1:0] acc_q, acc_d;
  logic signed [SUMW-1:0] sum_q, sum_d;
  logic                   sum_valid_q, sum_valid_d;

`ifdef ADC_BASELINE_SUB_EN
  logic signed [DW-1:0] base_q, base_d;
  logic signed [DW:0]   diff;

  always_comb begin
    base_d = acc_clr ? din : base_q;
    diff   = (DW+1)'(din) - (DW+1)'(base_q);
    term   = SUMW'(diff);
  end

  always_ff @(posedge clk) begin
    if (rst) base_q <= '0;
    else     base_q <= base_d;
  end
`else
  always_comb term = SUMW'(din);
`endif

  always_comb begin
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = done;
    if (acc_clr)     acc_d = '0;
    else if (acc_en) acc_d = acc_q + term;
    if (done)        sum_d = acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_adc_window_integrator.sv
// Self-checking bench for adc_window_integrator: vector table plus hand-written
// corner sequences, with results and trig_miss pulses tracked through queues.
module tb_adc_window_integrator;

  localparam int DW   = 13;
  localparam int LENW = 8;
  localparam int SUMW = 22;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic signed [DW-1:0]   din = '0;
  logic                   trig = 1'b0;
  logic        [LENW-1:0] delay = '0;
  logic        [LENW-1:0] len = '0;
  logic                   busy;
  logic signed [SUMW-1:0] sum_out;
  logic                   sum_valid;
  logic                   trig_miss;

  adc_window_integrator #(.DW(DW), .LENW(LENW), .SUMW(SUMW)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .trig      (trig),
    .delay     (delay),
    .len       (len),
    .busy      (busy),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .trig_miss (trig_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;      // 0 constant, 1 ramp from trigger, 2 step 50 -> 150
    int val;
    int dly;
    int ln;
    int exp_plain;
    int exp_base;
  } vec_t;

  typedef struct {
    int sum;
    int cyc;
  } res_t;

  vec_t vecs[8];
  res_t exp_q[$];
  int   miss_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic int din_at(int mode, int val, int k);
    if (mode == 1) return k;
    if (mode == 2) return (k == 0) ? 50 : 150;
    return val;
  endfunction

  function automatic int pick(int plain, int base);
`ifdef ADC_BASELINE_SUB_EN
    return base;
`else
    return plain;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  task automatic push_res(input int sum, input int at);
    res_t r;
    r.sum = sum;
    r.cyc = at;
    exp_q.push_back(r);
  endtask

  // Advance one edge, then compare any result or trig_miss pulse against the queues.
  task automatic tick();
    res_t r;
    int   m;
    @(posedge clk);
    cyc++;
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      r = exp_q.pop_front();
      n_cmp++; n_err++;
      $display("FAIL missing_valid: no strobe at cyc %0d, want sum %0d", r.cyc, r.sum);
    end
    while (miss_q.size() > 0 && miss_q[0] < cyc) begin
      m = miss_q.pop_front();
      n_cmp++; n_err++;
      $display("FAIL missing_trig_miss: no pulse at cyc %0d", m);
    end
    if (sum_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid at cyc %0d: sum %0d, want no strobe", cyc, int'(sum_out));
      end else begin
        r = exp_q.pop_front();
        if (int'(sum_out) != r.sum || cyc != r.cyc) begin
          n_err++;
          $display("FAIL result: got sum %0d at cyc %0d, want sum %0d at cyc %0d",
                   int'(sum_out), cyc, r.sum, r.cyc);
        end
      end
    end
    if (trig_miss) begin
      n_cmp++;
      if (miss_q.size() == 0 || miss_q[0] != cyc) begin
        n_err++;
        $display("FAIL trig_miss: pulse at cyc %0d, want %0d", cyc,
                 (miss_q.size() == 0) ? -1 : miss_q[0]);
      end else begin
        m = miss_q.pop_front();
      end
    end
  endtask

  initial begin
    int t0;
    int t1;

    vecs[0] = '{0,   100, 3, 4,     400,   0};
    vecs[1] = '{1,     0, 0, 5,      15,  15};
    vecs[2] = '{0, -4096, 0, 255, -1044480, 0};
    vecs[3] = '{2,     0, 1, 4,     600, 400};
    vecs[4] = '{0,     7, 2, 0,       0,   0};
    vecs[5] = '{0,    -3, 0, 0,       0,   0};
    vecs[6] = '{1,     0, 2, 3,      12,  12};
    vecs[7] = '{0,  4095, 0, 1,    4095,   0};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_sum_out", int'(sum_out), 0);
    chk("reset_sum_valid", int'(sum_valid), 0);
    chk("reset_trig_miss", int'(trig_miss), 0);
    tick();

    // Table-driven windows; delay/len are scrambled after acceptance to prove they are latched.
    for (int i = 0; i < 8; i++) begin
      delay = LENW'(vecs[i].dly);
      len   = LENW'(vecs[i].ln);
      din   = DW'(din_at(vecs[i].mode, vecs[i].val, 0));
      trig  = 1'b1;
      tick();
      t0    = cyc;
      trig  = 1'b0;
      delay = '1;
      len   = '1;
      push_res(pick(vecs[i].exp_plain, vecs[i].exp_base), t0 + vecs[i].dly + vecs[i].ln + 1);
      for (int k = 1; k <= vecs[i].dly + vecs[i].ln + 3; k++) begin
        din = DW'(din_at(vecs[i].mode, vecs[i].val, k));
        tick();
      end
    end

    // Busy profile and rejected second trigger during the delay phase.
    din = 100; delay = 3; len = 4;
    trig = 1'b1;
    tick();
    t0 = cyc;
    trig = 1'b0;
    push_res(pick(400, 0), t0 + 8);
    miss_q.push_back(t0 + 3);
    for (int k = 1; k <= 9; k++) begin
      trig = (k == 2);
      tick();
      chk("busy_window", int'(busy), int'(cyc >= t0 + 1 && cyc <= t0 + 7));
    end
    trig = 1'b0;

    // delay=0, len=0: immediate zero result, busy never rises.
    din = 9; delay = 0; len = 0;
    trig = 1'b1;
    tick();
    t0 = cyc;
    trig = 1'b0;
    push_res(0, t0 + 1);
    tick();
    chk("busy_len0", int'(busy), 0);
    tick();

    // Trigger sampled while sum_valid is high starts a new window.
    din = 10; delay = 0; len = 2;
    trig = 1'b1;
    tick();
    t0 = cyc;
    trig = 1'b0;
    push_res(pick(20, 0), t0 + 3);
    repeat (3) tick();
    chk("valid_before_retrig", int'(sum_valid), 1);
    trig = 1'b1;
    tick();
    t1 = cyc;
    trig = 1'b0;
    push_res(pick(20, 0), t1 + 3);
    tick();
    chk("busy_retrig", int'(busy), 1);
    repeat (4) tick();

    // Reset in the middle of accumulation abandons the window.
    din = 5; delay = 0; len = 10;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_acc_sum_out", int'(sum_out), 0);
    chk("rst_acc_sum_valid", int'(sum_valid), 0);
    chk("rst_acc_busy", int'(busy), 0);
    repeat (15) tick();

    // Fresh window after reset.
    delay = 1; len = 3;
    din = 50;
    trig = 1'b1;
    tick();
    t0 = cyc;
    trig = 1'b0;
    din = 150;
    push_res(pick(450, 300), t0 + 5);
    repeat (7) tick();

    for (int k = 0; k < 50 && (exp_q.size() > 0 || miss_q.size() > 0); k++) tick();
    while (exp_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_result: want sum %0d at cyc %0d", exp_q[0].sum, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    while (miss_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_trig_miss: want pulse at cyc %0d", miss_q[0]);
      void'(miss_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
